// File: rtl/boot_copier.sv
// Boot copier: copies word_count 32-bit words from a flash source to a RAM
// destination over a simple rd/we/ack bus, with a per-transfer ack timeout.
module boot_copier #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_base,
  input  logic [31:0] dst_base,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  output logic [1:0]  sel_o,
  output logic        rd_o,
  output logic        we_o,
  input  logic        ack_i
);

  localparam int unsigned WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT);
  localparam logic [31:0]   WORD_BYTES = 32'd4;
  localparam logic [1:0]    SEL_WORD   = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          rd_q, rd_d;
  logic          we_q, we_d;
  logic [31:0]   src_nxt, dst_nxt;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    we_d    = we_q;
    src_nxt = src_q + WORD_BYTES;
    dst_nxt = dst_q + WORD_BYTES;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (word_count == 16'd0) begin
            done_d = 1'b1;
          end else begin
            src_d   = src_base;
            dst_d   = dst_base;
            cnt_d   = word_count;
            wait_d  = '0;
            busy_d  = 1'b1;
            rd_d    = 1'b1;
            we_d    = 1'b0;
            addr_d  = src_base;
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        if (ack_i) begin
          data_d  = data_i;
          addr_d  = dst_q;
          rd_d    = 1'b0;
          we_d    = 1'b1;
          wait_d  = '0;
          state_d = S_WRITE;
        end else if (wait_q == WAIT_MAX) begin
          rd_d    = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      S_WRITE: begin
        if (ack_i) begin
          src_d  = src_nxt;
          dst_d  = dst_nxt;
          cnt_d  = cnt_q - 16'd1;
          wait_d = '0;
          we_d   = 1'b0;
          if (cnt_q == 16'd1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            rd_d    = 1'b1;
            addr_d  = src_nxt;
            state_d = S_READ;
          end
        end else if (wait_q == WAIT_MAX) begin
          rd_d    = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      default: begin
        rd_d    = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        wait_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops bus requests immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign rd_o   = rd_q;
  assign we_o   = we_q;
  assign sel_o  = SEL_WORD;

endmodule

// File: tb/tb_boot_copier.sv
// Bench for boot_copier: a randomized-latency bus responder backed by a flash
// model; copies are checked against address/data sequences computed arithmetically.
module tb_boot_copier;

  localparam int unsigned TO = 15;
  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_base, dst_base;
  logic [15:0] word_count;
  logic        busy, done, err;
  logic [31:0] addr_o, data_o, data_i;
  logic [1:0]  sel_o;
  logic        rd_o, we_o, ack_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] fmap [logic [31:0]];
  logic [31:0] rd_q[$];
  logic [31:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];

  boot_copier #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .word_count(word_count), .busy(busy), .done(done), .err(err), .addr_o(addr_o),
    .data_o(data_o), .data_i(data_i), .sel_o(sel_o), .rd_o(rd_o), .we_o(we_o),
    .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] flash(input logic [31:0] a);
    if (fmap.exists(a)) return fmap[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One copy with a responder that acks after a random delay in [mind,maxd];
  // at most ack_limit acks are given, the rest of the requests are left hanging.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int mind, input int maxd, input int ack_limit,
                          input bit noise, input string tag);
    int k, cyc, dones, pend, acks, req_cycles, to_len, budget;
    bit exp_to, in_req, both, unstable, finished, busy1, err1, quiet, req_rd;
    logic [31:0] req_a, req_dat, ea;
    k      = (ack_limit < 2 * n) ? ack_limit : 2 * n;
    exp_to = (ack_limit < 2 * n);
    budget = 2 * n * (maxd + 2) + 2 * (int'(TO) + 3) + 20;
    cyc = 0; dones = 0; pend = 0; acks = 0; req_cycles = 0; to_len = 0;
    in_req = 0; both = 0; unstable = 0; finished = 0; busy1 = 0; err1 = 0; quiet = 1;
    req_rd = 0; req_a = '0; req_dat = '0;
    rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();

    start = 1'b1; src_base = s; dst_base = d; word_count = 16'(n);
    while (!finished && cyc < budget) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (rd_o && we_o) both = 1;
      if (done) dones = dones + 1;
      if (cyc == 1) begin busy1 = busy; err1 = err; end
      if (!(rd_o || we_o) && in_req) begin to_len = req_cycles; in_req = 0; end
      if (!busy && !rd_o && !we_o) finished = 1;

      start = 1'b0; ack_i = 1'b0; data_i = $urandom;
      if (!finished) begin
        if (noise) begin
          start = 1'($urandom_range(1, 0));
          src_base = $urandom; dst_base = $urandom; word_count = 16'($urandom);
        end
        if (rd_o || we_o) begin
          if (!in_req) begin
            in_req = 1; pend = int'($urandom_range(maxd, mind));
            req_a = addr_o; req_dat = data_o; req_rd = rd_o; req_cycles = 0;
          end else if (addr_o !== req_a || rd_o !== req_rd || (we_o && data_o !== req_dat)) begin
            unstable = 1;
          end
          req_cycles = req_cycles + 1;
          if (pend == 0 && acks < ack_limit) begin
            ack_i = 1'b1; acks = acks + 1; in_req = 0;
            if (rd_o) begin
              rd_q.push_back(addr_o); data_i = flash(addr_o);
            end else begin
              wr_a_q.push_back(addr_o); wr_d_q.push_back(data_o);
            end
          end else if (pend > 0) begin
            pend = pend - 1;
          end
        end
      end
    end
    check({tag, ":finished"}, 32'(finished), 32'd1);

    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack_i = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      @(negedge clk);
      if (done) dones = dones + 1;
      if (rd_o || we_o || busy) quiet = 0;
    end
    ack_i = 1'b0;

    check({tag, ":busy_start"}, 32'(busy1), (n > 0) ? 32'd1 : 32'd0);
    check({tag, ":err_clear"}, 32'(err1), 32'd0);
    check({tag, ":done_count"}, 32'(dones), exp_to ? 32'd0 : 32'd1);
    check({tag, ":err_final"}, 32'(err), 32'(exp_to));
    check({tag, ":quiet"}, 32'(quiet), 32'd1);
    check({tag, ":overlap"}, 32'(both), 32'd0);
    check({tag, ":stable"}, 32'(unstable), 32'd0);
    check({tag, ":sel"}, 32'(sel_o), 32'd2);
    check({tag, ":n_reads"}, 32'(rd_q.size()), 32'((k + 1) / 2));
    check({tag, ":n_writes"}, 32'(wr_a_q.size()), 32'(k / 2));
    for (int i = 0; i < rd_q.size() && i < (k + 1) / 2; i++) begin
      ea = s + 32'(4 * i);
      check($sformatf("%s:rd_addr%0d", tag, i), rd_q[i], ea);
    end
    for (int i = 0; i < wr_a_q.size() && i < k / 2; i++) begin
      ea = s + 32'(4 * i);
      check($sformatf("%s:wr_addr%0d", tag, i), wr_a_q[i], d + 32'(4 * i));
      check($sformatf("%s:wr_data%0d", tag, i), wr_d_q[i], flash(ea));
    end
    if (exp_to) check({tag, ":timeout_len"}, 32'(to_len), 32'(TO + 1));
  endtask

  initial begin
    logic [31:0] rs, rdst;
    int cnt;
    bit got_we;

    rst = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; word_count = '0;
    data_i = '0; ack_i = 1'b0;
    fmap[32'h0000_0000] = 32'h1234_5678;
    fmap[32'h0000_0004] = 32'h8765_4321;
    fmap[32'h0000_0008] = 32'h1020_3040;

    #12;
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:err", 32'(err), 32'd0);
    check("rst:rd", 32'(rd_o), 32'd0);
    check("rst:we", 32'(we_o), 32'd0);
    check("rst:addr", addr_o, 32'd0);
    check("rst:data", data_o, 32'd0);
    check("rst:sel", 32'(sel_o), 32'd2);

    @(negedge clk);
    rst = 1'b1;
    run_copy(32'h0, 32'h1000, 3, 0, 0, BIG, 1'b0, "basic");
    run_copy(32'h40, 32'h80, 0, 0, 0, BIG, 1'b0, "zero");

    for (int t = 0; t < 3; t++) begin
      rs = $urandom & 32'hFFFF_FFFC; rdst = $urandom & 32'hFFFF_FFFC;
      cnt = int'($urandom_range(8, 1));
      run_copy(rs, rdst, cnt, 0, 3, BIG, 1'b0, $sformatf("rand%0d", t));
    end

    run_copy(32'h100, 32'h200, 2, 0, 1, 2, 1'b0, "timeout");
    run_copy(32'h300, 32'h400, 2, 0, 2, BIG, 1'b0, "after_to");
    run_copy(32'hFFFF_FFFC, 32'h500, 2, 0, 1, BIG, 1'b0, "wrap");
    check("wrap:second_read", (rd_q.size() > 1) ? rd_q[1] : 32'hDEAD_BEEF, 32'h0);
    run_copy(32'h600, 32'h700, 2, int'(TO), int'(TO), BIG, 1'b0, "ack_wins");

    // Reset while a write is pending
    @(negedge clk);
    start = 1'b1; src_base = 32'h2000; dst_base = 32'h3000; word_count = 16'd3;
    got_we = 0;
    for (int i = 0; i < 20 && !got_we; i++) begin
      @(negedge clk);
      start = 1'b0; ack_i = 1'b0;
      if (we_o) got_we = 1;
      else if (rd_o) begin ack_i = 1'b1; data_i = flash(addr_o); end
    end
    check("midrst:we_seen", 32'(got_we), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst:we", 32'(we_o), 32'd0);
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:rd", 32'(rd_o), 32'd0);
    check("midrst:addr", addr_o, 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || err) cnt = cnt + 1;
    end
    check("midrst:no_pulse", 32'(cnt), 32'd0);
    rst = 1'b1;
    run_copy(32'h4000, 32'h5000, 1, 0, 2, BIG, 1'b0, "post_rst");

    rs = $urandom & 32'hFFFF_FFFC; rdst = $urandom & 32'hFFFF_FFFC;
    run_copy(rs, rdst, 4, 0, 2, BIG, 1'b1, "noise");
    rs = $urandom & 32'hFFFF_FFFC; rdst = $urandom & 32'hFFFF_FFFC;
    run_copy(rs, rdst, 200, 0, 2, BIG, 1'b0, "long");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
